// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through capture FIFO for ALU result/carry pairs,
// with a saturating carry counter. Define ALU_RESULT_SUM_EN to add the sum_out running sum.
module alu_result_fifo #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_carry,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_carry,
    input  logic                       out_ready,
    input  logic                       clr_stats,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef ALU_RESULT_SUM_EN
    output logic [DATA_W+4:0]          sum_out,
`endif
    output logic [CNT_W-1:0]           carry_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_carry_cnt;

    logic              w_push;
    logic              w_pop;
    entry_t            w_head;

    // Full blocks pushes even when a pop is happening in the same cycle.
    assign in_ready  = (r_count != OCC_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_data  = w_head.data;
    assign out_carry = w_head.carry;
    assign count     = r_count;
    assign carry_cnt = r_carry_cnt;

    // NOTE: storage is deliberately not reset; out_valid gates the head so stale entries never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{carry: in_carry, data: in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_cnt <= '0;
        end else if (clr_stats) begin
            r_carry_cnt <= '0;
        end else if (w_push && in_carry && (r_carry_cnt != '1)) begin
            r_carry_cnt <= r_carry_cnt + CNT_W'(1);
        end
    end

`ifdef ALU_RESULT_SUM_EN
    logic [DATA_W+4:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clr_stats) begin
            r_sum <= '0;
        end else if (w_push) begin
            r_sum <= r_sum + (DATA_W+5)'({in_carry, in_data});
        end
    end

    assign sum_out = r_sum;
`endif

endmodule
